// File: rtl/sprite_if.sv
// Bundle between the video timing block, the sprite position controller and the renderer.
// The timing side (master) drives raster position and run; the controller (slave) returns position and status.
interface sprite_if;
  logic signed [10:0] spotX;
  logic signed [10:0] spotY;
  logic               run;
  logic signed [10:0] centerX;
  logic signed [10:0] centerY;
  logic               bounce;
  logic [7:0]         frame_cnt;

  modport master (
    output spotX, spotY, run,
    input  centerX, centerY, bounce, frame_cnt
  );

  modport slave (
    input  spotX, spotY, run,
    output centerX, centerY, bounce, frame_cnt
  );
endinterface

// File: rtl/sprite_ctrl.sv
// Bouncing-sprite position controller: steps the sprite centre once per frame during vertical
// blanking, clamping at the screen limits and flipping direction on each axis independently.
//
// state  | meaning
// IDLE   | waiting for a frame tick with run=1
// STEP_X | apply one horizontal step (clamp/flip at XMIN/XMAX)
// STEP_Y | apply one vertical step (clamp/flip at YMIN/YMAX)
module sprite_ctrl #(
  parameter int HACTIVE = 800,
  parameter int VACTIVE = 600,
  parameter int R       = 50,
  parameter int SPEED   = 2,
  parameter int X0      = 400,
  parameter int Y0      = 300
) (
  input  logic     clk,
  input  logic     reset_n,
  sprite_if.slave  bus
);

  localparam logic signed [11:0] XMIN  = 12'(R);
  localparam logic signed [11:0] XMAX  = 12'(HACTIVE - 1 - R);
  localparam logic signed [11:0] YMIN  = 12'(R);
  localparam logic signed [11:0] YMAX  = 12'(VACTIVE - 1 - R);
  localparam logic signed [11:0] STEP  = 12'(SPEED);
  localparam logic signed [11:0] VLIM  = 12'(VACTIVE);
  localparam logic signed [10:0] XRST  = 11'(X0);
  localparam logic signed [10:0] YRST  = 11'(Y0);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;

  state_t             state;
  logic signed [10:0] center_x, center_y;
  logic               dir_x, dir_y;
  logic               bounce_q;
  logic [7:0]         frame_q;
  logic               blank_q;

  logic               blank, tick;
  logic signed [11:0] spot_y_ext, cx_ext, cy_ext;
  logic signed [11:0] x_inc, x_dec, y_inc, y_dec;

  // spotX is part of the raster bundle but position updates only care about the line number
  logic unused_spot_x;
  assign unused_spot_x = ^bus.spotX;

  assign spot_y_ext = {bus.spotY[10], bus.spotY};
  assign cx_ext     = {center_x[10], center_x};
  assign cy_ext     = {center_y[10], center_y};
  assign x_inc      = cx_ext + STEP;
  assign x_dec      = cx_ext - STEP;
  assign y_inc      = cy_ext + STEP;
  assign y_dec      = cy_ext - STEP;

  assign blank = (spot_y_ext >= VLIM);
  assign tick  = blank & ~blank_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      center_x <= XRST;
      center_y <= YRST;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      bounce_q <= 1'b0;
      frame_q  <= 8'd0;
      blank_q  <= 1'b1;
    end else begin
      blank_q  <= blank;
      bounce_q <= 1'b0;
      if (tick) frame_q <= frame_q + 8'd1;

      case (state)
        IDLE: begin
          if (tick && bus.run) state <= STEP_X;
        end
        STEP_X: begin
          state <= STEP_Y;
          if (dir_x) begin
            if (x_inc > XMAX) begin
              center_x <= XMAX[10:0];
              dir_x    <= 1'b0;
              bounce_q <= 1'b1;
            end else begin
              center_x <= x_inc[10:0];
            end
          end else begin
            if (x_dec < XMIN) begin
              center_x <= XMIN[10:0];
              dir_x    <= 1'b1;
              bounce_q <= 1'b1;
            end else begin
              center_x <= x_dec[10:0];
            end
          end
        end
        STEP_Y: begin
          state <= IDLE;
          if (dir_y) begin
            if (y_inc > YMAX) begin
              center_y <= YMAX[10:0];
              dir_y    <= 1'b0;
              bounce_q <= 1'b1;
            end else begin
              center_y <= y_inc[10:0];
            end
          end else begin
            if (y_dec < YMIN) begin
              center_y <= YMIN[10:0];
              dir_y    <= 1'b1;
              bounce_q <= 1'b1;
            end else begin
              center_y <= y_dec[10:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.centerX   = center_x;
  assign bus.centerY   = center_y;
  assign bus.bounce    = bounce_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_sprite_ctrl.sv
// Self-checking bench for sprite_ctrl: a timestamp-scheduled reference model compared every cycle,
// directed frame sequences with literal expectations, then randomized raster/run/reset stimulus.
module tb_sprite_ctrl;
  localparam int HACTIVE = 800;
  localparam int VACTIVE = 600;
  localparam int R       = 50;
  localparam int SPEED   = 2;
  localparam int X0      = 400;
  localparam int Y0      = 300;
  localparam int XMAX    = HACTIVE - 1 - R;
  localparam int YMAX    = VACTIVE - 1 - R;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  sprite_if bus ();

  sprite_ctrl #(
    .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .R(R), .SPEED(SPEED), .X0(X0), .Y0(Y0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int bounce_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: positions as plain integers, updates scheduled by cycle number.
  int m_cx, m_cy, m_dx, m_dy, m_fc, m_bnc;
  bit m_blank_prev;
  longint cyc = 0, x_at = -1, y_at = -1, busy_until = -1;

  function automatic void move(inout int pos, inout int dir, input int lo, input int hi,
                               output int clamped);
    int nxt;
    nxt = pos + dir * SPEED;
    clamped = 0;
    if (nxt > hi)      begin pos = hi; dir = -1; clamped = 1; end
    else if (nxt < lo) begin pos = lo; dir = 1;  clamped = 1; end
    else               pos = nxt;
  endfunction

  always @(posedge clk) begin
    int cl, nb;
    bit blank, tick;
    if (!reset_n) begin
      m_cx = X0; m_cy = Y0; m_dx = 1; m_dy = 1; m_fc = 0; m_bnc = 0;
      m_blank_prev = 1'b1; x_at = -1; y_at = -1; busy_until = -1;
    end else begin
      blank = (int'(bus.spotY) >= VACTIVE);
      tick  = blank && !m_blank_prev;
      m_blank_prev = blank;
      nb = 0;
      if (cyc == x_at) begin move(m_cx, m_dx, R, XMAX, cl); nb = nb | cl; end
      if (cyc == y_at) begin move(m_cy, m_dy, R, YMAX, cl); nb = nb | cl; end
      if (tick) begin
        m_fc = (m_fc + 1) % 256;
        if (bus.run && cyc > busy_until) begin
          x_at = cyc + 1; y_at = cyc + 2; busy_until = cyc + 2;
        end
      end
      m_bnc = nb;
    end
    cyc++;
    #1;
    chk("centerX", int'(bus.centerX), m_cx);
    chk("centerY", int'(bus.centerY), m_cy);
    chk("bounce", int'(bus.bounce), m_bnc);
    chk("frame_cnt", int'(bus.frame_cnt), m_fc);
    if (bus.bounce === 1'b1) bounce_total++;
  end

  // One well-spaced frame: blanking for 3 cycles (tick, X, Y), then 2 active cycles.
  task automatic frame();
    repeat (3) begin @(negedge clk); bus.spotY = 11'sd600; end
    repeat (2) begin @(negedge clk); bus.spotY = 11'sd599; end
  endtask

  task automatic rframe();
    int k, m;
    k = $urandom_range(3, 1);
    m = $urandom_range(4, 1);
    repeat (k) begin
      @(negedge clk);
      bus.spotY = 11'($signed($urandom_range(619, 0)) - 20);
      if (bus.spotY >= 11'sd600) bus.spotY = 11'sd599;
      if ($urandom_range(3, 0) == 0) bus.run = ~bus.run;
      reset_n = ($urandom_range(60, 0) != 0);
    end
    repeat (m) begin
      @(negedge clk);
      bus.spotY = 11'($urandom_range(1023, 600));
      if ($urandom_range(3, 0) == 0) bus.run = ~bus.run;
      reset_n = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.spotX = 11'sd0;
    bus.spotY = 11'sd700;
    bus.run   = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_centerX", int'(bus.centerX), 400);
    chk("rst_centerY", int'(bus.centerY), 300);
    chk("rst_frame_no_tick", int'(bus.frame_cnt), 0);
    chk("rst_bounce", int'(bus.bounce), 0);
    bus.spotY = 11'sd599;
    repeat (2) @(negedge clk);

    bus.run = 1'b1;
    frame();
    chk("f1_centerX", int'(bus.centerX), 402);
    chk("f1_centerY", int'(bus.centerY), 302);
    chk("f1_frame_cnt", int'(bus.frame_cnt), 1);
    chk("f1_no_bounce", bounce_total, 0);

    for (int f = 2; f <= 124; f++) frame();
    chk("f124_centerY", int'(bus.centerY), 548);
    chk("f124_no_bounce", bounce_total, 0);
    frame();
    chk("f125_centerY_clamp", int'(bus.centerY), 549);
    chk("f125_centerX", int'(bus.centerX), 650);
    chk("f125_bounce_once", bounce_total, 1);
    frame();
    chk("f126_centerY", int'(bus.centerY), 547);
    for (int f = 127; f <= 175; f++) frame();
    chk("f175_centerX_clamp", int'(bus.centerX), 749);
    chk("f175_centerY", int'(bus.centerY), 449);
    chk("f175_bounce_once", bounce_total, 2);
    frame();
    chk("f176_centerX", int'(bus.centerX), 747);
    chk("f176_no_extra_bounce", bounce_total, 2);
    chk("f176_frame_cnt", int'(bus.frame_cnt), 176);

    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; bus.run = 1'b0;
    repeat (10) frame();
    chk("frozen_centerX", int'(bus.centerX), 400);
    chk("frozen_centerY", int'(bus.centerY), 300);
    chk("frozen_frame_cnt", int'(bus.frame_cnt), 10);
    repeat (246) frame();
    chk("wrap_frame_cnt", int'(bus.frame_cnt), 0);

    // reset while STEP_Y is pending: X already moved, Y update must be discarded
    bus.run = 1'b1;
    @(negedge clk); bus.spotY = 11'sd600;
    @(negedge clk);
    @(negedge clk);
    chk("midupd_centerX", int'(bus.centerX), 402);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_centerX", int'(bus.centerX), 400);
    chk("midrst_centerY", int'(bus.centerY), 300);
    reset_n = 1'b1; bus.spotY = 11'sd599;
    @(negedge clk);
    frame();
    chk("postrst_centerX", int'(bus.centerX), 402);
    chk("postrst_centerY", int'(bus.centerY), 302);

    for (int f = 0; f < 400; f++) rframe();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
